// File: rtl/preview_fifo_pkg.sv
// preview_fifo_pkg: shared encodings and types for preview_fifo and its write arbiter
package preview_fifo_pkg;
  localparam logic [2:0] WRREQ_IDLE = 3'b001;
  localparam logic [2:0] WRREQ_ONE  = 3'b010;
  localparam logic [2:0] WRREQ_TWO  = 3'b100;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1) % n;
  endfunction
endpackage

// File: rtl/preview_fifo_rr_pick.sv
// preview_fifo_rr_pick: first asserted request at or after ptr, wrapping modulo N
module preview_fifo_rr_pick #(
  parameter int N = 2,
  localparam int CW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [CW-1:0] gnt_idx,
  output logic          gnt_any
);
  // scan farthest offset first so the nearest request from ptr wins
  always_comb begin
    gnt_idx = ptr;
    gnt_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt_idx = CW'((int'(ptr) + k) % N);
        gnt_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/preview_fifo_wr_arb.sv
// preview_fifo_wr_arb: round-robin packet arbiter for the preview_fifo write port
module preview_fifo_wr_arb
  import preview_fifo_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int N       = 2,
  parameter int TIMEOUT = 16,
  localparam int CW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [N-1:0]     req_two,
  input  logic [N-1:0]     req_last,
  input  logic [N*WIDTH-1:0] req_d0,
  input  logic [N*WIDTH-1:0] req_d1,
  output logic [N-1:0]     req_ready,
  input  logic [1:0]       full,
  output logic [2:0]       wrreq,
  output logic [WIDTH-1:0] id0,
  output logic [WIDTH-1:0] id1,
  output logic             busy,
  output logic [CW-1:0]    owner,
  output logic             err_timeout,
  output logic [31:0]      wr_words
);
  localparam int WDW = $clog2(TIMEOUT);
  arb_state_e state, nstate;
  logic [CW-1:0] rr_ptr, pick_idx, w;
  logic [WDW-1:0] wd_cnt;
  logic [WIDTH-1:0] id0_q, id1_q;
  logic pick_any, two, last, acc, wd_to;
  preview_fifo_rr_pick #(.N(N)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt_idx(pick_idx),
    .gnt_any(pick_any)
  );
  assign w     = state == ARB_LOCKED ? owner : pick_idx;
  assign two   = req_two[w];
  assign last  = req_last[w];
  assign acc   = ~rst & (state == ARB_LOCKED ? req_valid[w] : pick_any) & (two ? ~full[1] : ~full[0]);
  assign wd_to = state == ARB_LOCKED & ~req_valid[owner] & wd_cnt == WDW'(TIMEOUT - 1);
  assign busy  = state == ARB_LOCKED;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ARB_IDLE;
    else state <= nstate;
  // lock on a non-last beat, release on a last beat or watchdog expiry
  always_comb
    nstate = state == ARB_IDLE ? (acc & ~last ? ARB_LOCKED : ARB_IDLE)
                               : ((acc & last) | wd_to ? ARB_IDLE : ARB_LOCKED);
  // handshake and FIFO write port; data holds its last written value when idle
  always_comb begin
    req_ready = acc ? {{(N-1){1'b0}}, 1'b1} << w : '0;
    wrreq     = acc ? (two ? WRREQ_TWO : WRREQ_ONE) : WRREQ_IDLE;
    id0       = acc ? req_d0[w*WIDTH +: WIDTH] : id0_q;
    id1       = acc ? req_d1[w*WIDTH +: WIDTH] : id1_q;
  end
  // pointer, owner, watchdog, word counter and data hold registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr_ptr      <= '0;
      owner       <= '0;
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
      wr_words    <= '0;
      id0_q       <= '0;
      id1_q       <= '0;
    end else begin
      rr_ptr      <= (acc & last) ? CW'(wrap_inc(int'(w), N)) : wd_to ? CW'(wrap_inc(int'(owner), N)) : rr_ptr;
      owner       <= acc ? w : owner;
      wd_cnt      <= busy & ~req_valid[owner] & ~wd_to ? wd_cnt + 1'b1 : '0;
      err_timeout <= wd_to;
      wr_words    <= wr_words + (acc ? (two ? 32'd2 : 32'd1) : 32'd0);
      id0_q       <= acc ? req_d0[w*WIDTH +: WIDTH] : id0_q;
      id1_q       <= acc ? req_d1[w*WIDTH +: WIDTH] : id1_q;
    end
endmodule

// File: tb/tb_preview_fifo_wr_arb.sv
// tb_preview_fifo_wr_arb: directed plan items plus randomized traffic against a packet-level model
module tb_preview_fifo_wr_arb;
  localparam int WIDTH = 8, N = 2, TIMEOUT = 16, CW = $clog2(N);
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] v = '0, tw = '0, la = '0, req_ready, held = '0;
  logic [WIDTH-1:0] d0 [N], d1 [N];
  logic [N*WIDTH-1:0] req_d0, req_d1;
  logic [1:0] full = 2'b00;
  logic [2:0] wrreq;
  logic [WIDTH-1:0] id0, id1;
  logic busy, err_timeout;
  logic [CW-1:0] owner;
  logic [31:0] wr_words;
  bit m_locked, m_err;
  int m_owner, m_rr, m_idle, n_chk = 0, n_pass = 0, mute [N];
  logic [31:0] m_words;
  logic [WIDTH-1:0] m_id0;

  always #5 clk = ~clk;

  always_comb begin
    req_d0 = '0;
    req_d1 = '0;
    for (int i = 0; i < N; i++) begin
      req_d0[i*WIDTH +: WIDTH] = d0[i];
      req_d1[i*WIDTH +: WIDTH] = d1[i];
    end
  end

  preview_fifo_wr_arb #(.WIDTH(WIDTH), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(v), .req_two(tw), .req_last(la),
    .req_d0(req_d0), .req_d1(req_d1), .req_ready(req_ready), .full(full),
    .wrreq(wrreq), .id0(id0), .id1(id1), .busy(busy), .owner(owner),
    .err_timeout(err_timeout), .wr_words(wr_words)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic m_reset();
    m_locked = 0; m_err = 0; m_owner = 0; m_rr = 0; m_idle = 0;
    m_words = '0; m_id0 = '0; held = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; v = '0; tw = '0; la = '0; full = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic set_req(input int i, input bit val, input bit two, input bit last);
    v[i] = val; tw[i] = two; la[i] = last;
    d0[i] = WIDTH'($urandom); d1[i] = WIDTH'($urandom);
  endtask

  // compare one cycle against the model, then advance model across the rising edge
  task automatic tick();
    int w;
    bit acc, two, last, was_locked;
    logic [N-1:0] er;
    #2;
    if (m_locked) w = m_owner;
    else begin
      w = m_rr;
      for (int k = N - 1; k >= 0; k--) if (v[(m_rr + k) % N]) w = (m_rr + k) % N;
    end
    two = tw[w]; last = la[w];
    acc = v[w] && (two ? !full[1] : !full[0]);
    er = '0;
    if (acc) er[w] = 1'b1;
    chk("ready", 64'(req_ready), 64'(er));
    chk("wrreq", 64'(wrreq), acc ? (two ? 64'h4 : 64'h2) : 64'h1);
    chk("id0", 64'(id0), acc ? 64'(d0[w]) : 64'(m_id0));
    if (acc && two) chk("id1", 64'(id1), 64'(d1[w]));
    chk("busy", 64'(busy), 64'(m_locked));
    chk("wr_words", 64'(wr_words), 64'(m_words));
    chk("err_timeout", 64'(err_timeout), 64'(m_err));
    if (m_locked) chk("owner", 64'(owner), 64'(m_owner));
    held = v & ~er;
    @(posedge clk);
    was_locked = m_locked;
    m_err = 0;
    if (acc) begin
      m_words = m_words + (two ? 2 : 1);
      m_id0 = d0[w];
      if (last) begin m_locked = 0; m_rr = (w + 1) % N; end
      else if (!was_locked) begin m_locked = 1; m_owner = w; end
    end
    if (was_locked && !v[m_owner]) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin m_locked = 0; m_rr = (m_owner + 1) % N; m_err = 1; m_idle = 0; end
    end else m_idle = 0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin d0[i] = '0; d1[i] = '0; mute[i] = 0; end
    m_reset();
    do_reset();
    tick();
    // two single-word requesters alternate
    for (int c = 0; c < 8; c++) begin
      set_req(0, 1, 0, 1); set_req(1, 1, 0, 1);
      tick();
    end
    chk("tp1_words", 64'(wr_words), 64'd8);
    // three-beat packet from requester 0 blocks requester 1
    do_reset();
    for (int b = 0; b < 3; b++) begin
      set_req(0, 1, b < 2, b == 2); set_req(1, 1, 0, 1);
      #1 chk("tp2_r1_blocked", 64'(req_ready[1]), 64'd0);
      tick();
    end
    chk("tp2_words", 64'(wr_words), 64'd5);
    set_req(0, 1, 0, 1);
    #1 chk("tp2_r1_grant", 64'(req_ready), 64'b10);
    tick();
    // no head-of-line skipping under partial full
    do_reset();
    full = 2'b10; set_req(0, 1, 1, 1); set_req(1, 1, 0, 1);
    #1 chk("tp3_stall", 64'(wrreq), 64'h1);
    tick();
    full = 2'b00;
    #1 chk("tp3_go", 64'(wrreq), 64'h4);
    tick();
    // watchdog release after requester 1 abandons its lock
    do_reset();
    set_req(1, 1, 0, 0);
    tick();
    v = '0;
    n = 0;
    while (!err_timeout && n < 40) begin tick(); n++; end
    chk("tp4_latency", 64'(n), 64'd16);
    chk("tp4_busy", 64'(busy), 64'd0);
    set_req(0, 1, 0, 1); set_req(1, 1, 0, 1);
    #1 chk("tp4_next", 64'(req_ready), 64'b01);
    tick();
    // asynchronous reset in the middle of a packet
    do_reset();
    set_req(0, 1, 0, 0);
    tick();
    set_req(0, 1, 1, 0); set_req(1, 1, 0, 1);
    #2 rst = 1'b1;
    #1 chk("tp5_ready", 64'(req_ready), 64'd0);
    chk("tp5_wrreq", 64'(wrreq), 64'h1);
    chk("tp5_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    chk("tp5_words", 64'(wr_words), 64'd0);
    set_req(0, 1, 0, 1); set_req(1, 1, 0, 1);
    #1 chk("tp5_rr", 64'(req_ready), 64'b01);
    tick();
    // randomized traffic with stalls, backpressure and abandoned locks
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!held[i]) begin
          if (mute[i] > 0) begin v[i] = 0; mute[i]--; end
          else begin
            set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 40) == 0) mute[i] = $urandom_range(5, 25);
          end
        end
      end
      n = $urandom_range(0, 5);
      full = n == 0 ? 2'b11 : n == 1 ? 2'b10 : 2'b00;
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/preview_fifo_wr_arb.md
# preview_fifo_wr_arb

Write-side arbiter sharing one `preview_fifo` write port between N requesters. Each requester offers one or two words per beat over a valid/ready handshake and may lock the port for a multi-beat packet. The arbiter uses round-robin selection between packets, honours the FIFO's per-width full flags, and releases a stalled lock with a watchdog. It sits directly in front of `preview_fifo`, driving `wrreq`/`id0`/`id1`.

## Interface
- `WIDTH`, 8: FIFO word width.
- `N`, 2: number of requesters, 2..8; `CW = $clog2(N)` is local.
- `TIMEOUT`, 16: idle cycles of a locked owner before forced release, ≥2.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in N: requester i offers a beat.
- `req_two` in N: beat carries two words (d0 then d1); 0 means d0 only.
- `req_last` in N: beat ends the packet.
- `req_d0` in N*WIDTH: first word, requester i at `[i*WIDTH +: WIDTH]`.
- `req_d1` in N*WIDTH: second word, ignored when `req_two`=0.
- `req_ready` out N: beat from requester i accepted this cycle.
- `full` in 2: from FIFO; `full[0]`=no room for 1 word, `full[1]`=no room for 2 words.
- `wrreq` out 3: to FIFO, one-hot: 001 idle, 010 one word, 100 two words.
- `id0`, `id1` out WIDTH: to FIFO data inputs.
- `busy` out 1: a packet lock is held.
- `owner` out CW: current or last granted requester.
- `err_timeout` out 1: one-cycle pulse on watchdog release.
- `wr_words` out 32: total words written, wraps at 2^32.

## Operation
- States: IDLE (no lock) and LOCKED (owner holds the port).
- Winner selection:
  - IDLE: winner is the first i with `req_valid[i]`, searching from `rr_ptr` upward modulo N.
  - LOCKED: winner is `owner`; other requesters are never ready.
- Fit rule: `fit = req_two[w] ? ~full[1] : ~full[0]`.
- `req_ready[w] = req_valid[w] & fit`; all other ready bits are 0.
- Accepted beat: `wrreq` = 010 or 100, `id0`/`id1` = winner's data. Otherwise `wrreq` = 001 and `id0`/`id1` hold their previous value. `id1` is don't-care for one-word writes.
- No head-of-line skipping: if the IDLE winner does not fit, the cycle stalls even if another requester would fit.
- Transitions on an accepted beat:
  - IDLE, last=1: stay IDLE; `rr_ptr` = w+1 mod N.
  - IDLE, last=0: go LOCKED; `owner` = w.
  - LOCKED, last=1: go IDLE; `rr_ptr` = owner+1 mod N.
- Watchdog:
  - `wd_cnt` counts cycles in LOCKED with `req_valid[owner]`=0. It clears on any owner valid, including valid while stalled on full.
  - When `wd_cnt` reaches TIMEOUT-1 with owner still invalid: go IDLE, `rr_ptr` = owner+1, `err_timeout` = 1 for one cycle.
  - FIFO backpressure never triggers the watchdog.
- `wr_words` += 1 or 2 per accepted beat.
- Requester rules: valid/two/last/data must stay stable while valid and not ready. Behaviour is undefined otherwise.

## Timing
- `req_ready`, `wrreq`, `id0`/`id1` are combinational from requests, `full` and registered state. Zero-cycle acceptance; `full` must be registered inside the FIFO.
- State, `rr_ptr`, `owner`, `wd_cnt`, `wr_words`, `err_timeout` and the `id0`/`id1` hold registers are registered.
- Reset values: IDLE, `rr_ptr`=0, `owner`=0, `wd_cnt`=0, `busy`=0, `err_timeout`=0, `wr_words`=0, `id0`/`id1`=0.
- While `rst`=1, `req_ready`=0 and `wrreq`=001 regardless of inputs.
- Reset mid-packet drops the lock; no beat is written in the reset cycle.
- `full` = 2'b11: no transfer.
- `full` = 2'b10: one-word beats only.
- Last beat of a packet followed by another requester's beat: the new grant takes effect the next cycle, with no bubble beyond that cycle.
- A lock with a single requester valid continuously sustains one beat per cycle.

## Structure
- `preview_fifo_pkg`:
  - wrreq encodings `WRREQ_IDLE`=3'b001, `WRREQ_ONE`=3'b010, `WRREQ_TWO`=3'b100.
  - arbiter state enum {ARB_IDLE, ARB_LOCKED}.
  - Shared with `preview_fifo` and its benches.
- Sub-module `preview_fifo_rr_pick`: combinational N-bit round-robin picker with inputs `req[N]`, `ptr[CW]`, outputs `gnt_idx[CW]`, `gnt_any`.
- Top-level file holds the FSM, watchdog, counters and the data mux.

## Test plan
- N=2, both valid single-word last=1 beats every cycle, full=00 → grants alternate 0,1,0,1; `wrreq`=010 every cycle; `wr_words`=8 after 8 cycles.
- Req0 sends a 3-beat packet (two,two,last one) while req1 valid → req1 ready stays 0 for 3 cycles; `wr_words`=5; req1 granted on cycle 4.
- full=10 while the IDLE winner is req0 two-word and req1 offers one word → no transfer, `wrreq`=001; full→00 → req0 accepted, `wrreq`=100.
- Req1 locks (last=0) then drops valid, TIMEOUT=16 → `err_timeout` pulses exactly 16 cycles later, `busy`=0, next grant goes to req0.
- `rst` asserted mid-packet asynchronously → `req_ready`=0, `wrreq`=001 immediately; after release `busy`=0, `wr_words`=0, `rr_ptr` restarts at requester 0.
